// File: rtl/cpu_muldiv.sv
// cpu_muldiv: iterative RV32M multiply/divide unit sitting beside the ALU in
// the execute stage. Every operation takes the same fixed number of cycles
// (one shift-add or restoring-divide step per clock) while the pipeline
// stalls; the registered result feeds the execute result mux.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset
//   start   request, accepted only while ready=1 and flush=0
//   op      funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   src_a   rs1 operand, captured on accept
//   src_b   rs2 operand, captured on accept
//   flush   abort the in-flight operation
//   ready   unit idle, able to accept
//   valid   one-cycle result pulse
//   result  result, held until overwritten by a later completion or reset
module cpu_muldiv #(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            ready,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(ITERS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction

  // Magnitude of x when it is to be read as a negative signed value.
  function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_neg);
    return is_neg ? neg32(x) : x;
  endfunction

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       op_r;
  logic [31:0]      opa_r;     // |src_a|: multiplicand / dividend magnitude
  logic [31:0]      opb_r;     // |src_b|: divisor magnitude
  logic [31:0]      a_raw_r;   // untouched src_a, returned by REM on divide-by-zero
  logic [63:0]      prod_r;    // multiply accumulator, multiplier starts in low half
  logic [31:0]      rem_r;     // partial remainder
  logic [31:0]      quo_r;     // dividend shifts out, quotient shifts in
  logic             neg_r;     // product / quotient must be negated
  logic             rneg_r;    // remainder must be negated (dividend negative)
  logic             divz_r;
  logic             ovf_r;
  logic             ready_r;
  logic             valid_r;
  logic [31:0]      result_r;

  logic        a_signed_s;
  logic        b_signed_s;
  logic        a_neg_s;
  logic        b_neg_s;
  logic        divz_s;
  logic        ovf_s;
  logic [32:0] mul_sum_s;
  logic [63:0] prod_nxt_s;
  logic [63:0] prod_fix_s;
  logic [32:0] div_shift_s;
  logic [31:0] rem_nxt_s;
  logic [31:0] quo_nxt_s;
  logic [31:0] res_s;

  // Operand signedness for the op presented at accept.
  always_comb begin
    a_signed_s = 1'b0;
    b_signed_s = 1'b0;
    case (op)
      OP_MULH, OP_DIV, OP_REM: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b1;
      end
      OP_MULHSU: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b0;
      end
      default: begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
      end
    endcase
  end

  assign a_neg_s = a_signed_s & src_a[31];
  assign b_neg_s = b_signed_s & src_b[31];
  assign divz_s  = op[2] & (src_b == 32'd0);
  assign ovf_s   = ((op == OP_DIV) || (op == OP_REM)) &&
                   (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);

  // One iteration of both datapaths; the FSM decides whether to commit it.
  always_comb begin
    mul_sum_s   = {1'b0, prod_r[63:32]} + (prod_r[0] ? {1'b0, opa_r} : 33'd0);
    prod_nxt_s  = {mul_sum_s, prod_r[31:1]};
    div_shift_s = {rem_r, quo_r[31]};
    if (div_shift_s >= {1'b0, opb_r}) begin
      rem_nxt_s = 32'(div_shift_s - {1'b0, opb_r});
      quo_nxt_s = {quo_r[30:0], 1'b1};
    end else begin
      rem_nxt_s = div_shift_s[31:0];
      quo_nxt_s = {quo_r[30:0], 1'b0};
    end
  end

  // Final result from the last iteration's values, sign fixes and special cases.
  always_comb begin
    prod_fix_s = neg_r ? neg64(prod_nxt_s) : prod_nxt_s;
    res_s      = 32'd0;
    case (op_r)
      OP_MUL: begin
        res_s = prod_fix_s[31:0];
      end
      OP_MULH, OP_MULHSU, OP_MULHU: begin
        res_s = prod_fix_s[63:32];
      end
      OP_DIV, OP_DIVU: begin
        if (divz_r) begin
          res_s = 32'hFFFF_FFFF;
        end else if (ovf_r) begin
          res_s = 32'h8000_0000;
        end else begin
          res_s = neg_r ? neg32(quo_nxt_s) : quo_nxt_s;
        end
      end
      OP_REM, OP_REMU: begin
        if (divz_r) begin
          res_s = a_raw_r;
        end else if (ovf_r) begin
          res_s = 32'd0;
        end else begin
          res_s = rneg_r ? neg32(rem_nxt_s) : rem_nxt_s;
        end
      end
      default: begin
        res_s = 32'd0;
      end
    endcase
  end

  // Control FSM with iteration datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      op_r     <= 3'd0;
      opa_r    <= 32'd0;
      opb_r    <= 32'd0;
      a_raw_r  <= 32'd0;
      prod_r   <= 64'd0;
      rem_r    <= 32'd0;
      quo_r    <= 32'd0;
      neg_r    <= 1'b0;
      rneg_r   <= 1'b0;
      divz_r   <= 1'b0;
      ovf_r    <= 1'b0;
      ready_r  <= 1'b1;
      valid_r  <= 1'b0;
      result_r <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          valid_r <= 1'b0;
          if (start && !flush) begin
            state_r <= ST_BUSY;
            ready_r <= 1'b0;
            cnt_r   <= '0;
            op_r    <= op;
            opa_r   <= mag32(src_a, a_neg_s);
            opb_r   <= mag32(src_b, b_neg_s);
            a_raw_r <= src_a;
            prod_r  <= {32'd0, mag32(src_b, b_neg_s)};
            rem_r   <= 32'd0;
            quo_r   <= mag32(src_a, a_neg_s);
            neg_r   <= a_neg_s ^ b_neg_s;
            rneg_r  <= a_neg_s;
            divz_r  <= divz_s;
            ovf_r   <= ovf_s;
          end else begin
            ready_r <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (flush) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
          end else begin
            prod_r <= prod_nxt_s;
            rem_r  <= rem_nxt_s;
            quo_r  <= quo_nxt_s;
            cnt_r  <= cnt_r + CNT_W'(1);
            if (cnt_r == LAST_CNT) begin
              state_r  <= ST_DONE;
              valid_r  <= 1'b1;
              result_r <= res_s;
            end else begin
              valid_r <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          // Leave after exactly one cycle; a flush here changes nothing extra.
          state_r <= ST_IDLE;
          ready_r <= 1'b1;
          valid_r <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          ready_r <= 1'b1;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign ready  = ready_r;
  assign valid  = valid_r;
  assign result = result_r;

endmodule

// File: tb/tb_cpu_muldiv.sv
// Directed bench for cpu_muldiv: an arithmetic reference model plus a
// cycle-level expectation of ready/valid/result, compared every cycle.
module tb_cpu_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        ready;
  logic        valid;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

  cpu_muldiv #(.XLEN(32), .ITERS(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .flush  (flush),
    .ready  (ready),
    .valid  (valid),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  // Reference arithmetic straight from the RV32M definitions.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, ua;
    logic [63:0] p;
    logic [31:0] r;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = 32'd0;
    case (o)
      3'b000: begin p = sa * sb; r = p[31:0]; end
      3'b001: begin p = sa * sb; r = p[63:32]; end
      3'b010: begin p = sa * ua; r = p[63:32]; end
      3'b011: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      3'b100: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (ovf) r = 32'h8000_0000;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'b101: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 32'd0) r = a;
        else if (ovf) r = 32'd0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      3'b111: r = (b == 32'd0) ? a : a % b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Cycle expectation: m_left counts cycles until the unit is idle again.
  int          m_left  = 0;
  logic [31:0] m_res   = 32'd0;
  logic [31:0] m_pend  = 32'd0;
  bit          model_on = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_left <= 0;
      m_res  <= 32'd0;
    end else if (m_left > 0) begin
      if (flush) m_left <= 0;
      else begin
        m_left <= m_left - 1;
        if (m_left == 2) m_res <= m_pend;
      end
    end else if (start && !flush) begin
      m_left <= 33;
      m_pend <= model(op, src_a, src_b);
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("cyc_ready", 32'(ready), 32'(m_left == 0));
      check("cyc_valid", 32'(valid), 32'(m_left == 1));
      check("cyc_result", result, m_res);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a request and step until the edge that accepts it.
  task automatic accept_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bit acc;
    bit r;
    start = 1'b1; op = o; src_a = a; src_b = b; acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      r = ready;
      step();
      acc = r;
    end
    check("accept", 32'(acc), 32'd1);
  endtask

  // Full operation; returns while valid is high so the next call overlaps it.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit hold, input string nm);
    int edges;
    accept_op(o, a, b);
    if (!hold) start = 1'b0;
    src_a = $urandom;
    src_b = $urandom;
    edges = 0;
    while (!valid && edges < 40) begin
      step();
      edges++;
      if (hold) begin
        src_a = $urandom;
        src_b = $urandom;
      end
    end
    start = 1'b0;
    check({nm, "_latency"}, 32'(edges), 32'd32);
    check({nm, "_result"}, result, exp);
  endtask

  typedef struct {
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;

  vec_t vecs [13] = '{
    '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB},
    '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000},
    '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
    '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
    '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
    '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
    '{3'b101, 32'd100,       32'd7,         32'd14},
    '{3'b111, 32'd100,       32'd7,         32'd2},
    '{3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF},
    '{3'b111, 32'd5,         32'd0,         32'd5},
    '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
    '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000},
    '{3'b101, 32'd100,       32'd7,         32'd14}
  };

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    bit seen;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; src_a = 32'd0; src_b = 32'd0;
    step();
    step();
    rst_n = 1'b1;
    model_on = 1'b1;
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_result", result, 32'd0);

    // Directed vectors, each issued in the previous op's valid cycle.
    foreach (vecs[i]) begin
      check($sformatf("pin_model_%0d", i), model(vecs[i].o, vecs[i].a, vecs[i].b), vecs[i].e);
      run_op(vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].e, 1'b0, $sformatf("vec%0d", i));
    end
    step();

    // Flush a DIV at iteration 10: no valid, result keeps 14.
    accept_op(3'b100, 32'd1000, 32'd3);
    start = 1'b0;
    repeat (10) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_ready", 32'(ready), 32'd1);
    check("flush_valid", 32'(valid), 32'd0);
    check("flush_result", result, 32'd14);
    seen = 1'b0;
    repeat (40) begin
      step();
      if (valid) seen = 1'b1;
    end
    check("flush_no_valid", 32'(seen), 32'd0);

    // MUL 3x4 with start held high throughout the busy period.
    run_op(3'b000, 32'd3, 32'd4, 32'd12, 1'b1, "mul_hold");
    step();

    // flush and start together in IDLE: nothing accepted.
    start = 1'b1; flush = 1'b1; op = 3'b000; src_a = 32'd9; src_b = 32'd9;
    step();
    start = 1'b0; flush = 1'b0;
    check("flush_start_ready", 32'(ready), 32'd1);
    step();
    check("flush_start_idle", 32'(ready), 32'd1);

    // Reset in the middle of BUSY.
    accept_op(3'b011, 32'hFFFF_FFFF, 32'h1234_5678);
    start = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_result", result, 32'd0);

    // Back-to-back after reset.
    run_op(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "b2b_mul");
    run_op(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, "b2b_rem");
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
